// File: rtl/beam_timing_gen.sv
// Raster timing generator: h/v counters, linear pixel address and LAT-delayed sync strobes.
// Optional per-line interrupt output is built when BEAM_LINE_IRQ_EN is defined.
module beam_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned LAT      = 0,
    parameter int unsigned POS_W    = 19,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
`ifdef BEAM_LINE_IRQ_EN
    input  logic [Y_W-1:0]   iIrqLine,
    output logic             oLineIrq,
`endif
    output logic             oDE,
    output logic             oHS,
    output logic             oVS,
    output logic             oFrameStart,
    output logic             oLineStart,
    output logic [POS_W-1:0] oPos,
    output logic [X_W-1:0]   oX,
    output logic [Y_W-1:0]   oY
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] HLast = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] HAct  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HsBeg = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HsEnd = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VLast = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] VAct  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VsBeg = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VsEnd = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned BitDe  = 0;
    localparam int unsigned BitHs  = 1;
    localparam int unsigned BitVs  = 2;
    localparam int unsigned BitFs  = 3;
    localparam int unsigned BitLs  = 4;
`ifdef BEAM_LINE_IRQ_EN
    localparam int unsigned BitIrq = 5;
    localparam int unsigned PW     = 6;
`else
    localparam int unsigned PW     = 5;
`endif
    // Sync bits are stored at their output level, so reset parks them inactive.
    localparam logic [PW-1:0] PipeRst = PW'({~VS_POL, ~HS_POL, 1'b0});

    logic [X_W-1:0]   hcnt_q, hcnt_d;
    logic [Y_W-1:0]   vcnt_q, vcnt_d;
    logic [POS_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [POS_W-1:0] pos_q;
    logic             h_last, v_last, de;
    logic [PW-1:0]    dec;
    logic [PW-1:0]    pipe_q [LAT+1];
    logic [PW-1:0]    pipe_d [LAT+1];

`ifdef BEAM_LINE_IRQ_EN
    logic [Y_W-1:0]   irq_line_q, irq_line_d;
`endif

    always_comb begin
        h_last = (hcnt_q == HLast);
        v_last = (vcnt_q == VLast);
        de     = (hcnt_q < HAct) && (vcnt_q < VAct);

        hcnt_d = h_last ? '0 : hcnt_q + X_W'(1);
        vcnt_d = vcnt_q;
        if (h_last) begin
            vcnt_d = v_last ? '0 : vcnt_q + Y_W'(1);
        end

        // Address of the next active pixel; parks at H_ACTIVE*V_ACTIVE in vblank.
        addr_d = addr_q;
        if (h_last && v_last) begin
            addr_d = '0;
        end else if (de) begin
            addr_d = addr_q + POS_W'(1);
        end

        dec        = '0;
        dec[BitDe] = de;
        dec[BitHs] = (hcnt_q >= HsBeg && hcnt_q < HsEnd) ? HS_POL : ~HS_POL;
        dec[BitVs] = (vcnt_q >= VsBeg && vcnt_q < VsEnd) ? VS_POL : ~VS_POL;
        dec[BitFs] = (hcnt_q == '0) && (vcnt_q == '0);
        dec[BitLs] = (hcnt_q == '0) && (vcnt_q < VAct);

`ifdef BEAM_LINE_IRQ_EN
        // Latched while leaving (0,0) so it also covers the first frame after reset.
        irq_line_d  = ((hcnt_q == '0) && (vcnt_q == '0)) ? iIrqLine : irq_line_q;
        dec[BitIrq] = (hcnt_q == HAct) && (vcnt_q == irq_line_q)
                      && (32'(irq_line_q) < V_TOTAL);
`endif

        pipe_d[0] = dec;
        for (int unsigned i = 1; i <= LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            pos_q  <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                pipe_q[i] <= PipeRst;
            end
        end else if (iEn) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            addr_q <= addr_d;
            x_q    <= hcnt_q;
            y_q    <= vcnt_q;
            pos_q  <= addr_q;
            for (int unsigned i = 0; i <= LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

`ifdef BEAM_LINE_IRQ_EN
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            irq_line_q <= '0;
        end else if (iEn) begin
            irq_line_q <= irq_line_d;
        end
    end

    assign oLineIrq = pipe_q[LAT][BitIrq];
`endif

    assign oDE         = pipe_q[LAT][BitDe];
    assign oHS         = pipe_q[LAT][BitHs];
    assign oVS         = pipe_q[LAT][BitVs];
    assign oFrameStart = pipe_q[LAT][BitFs];
    assign oLineStart  = pipe_q[LAT][BitLs];
    assign oPos        = pos_q;
    assign oX          = x_q;
    assign oY          = y_q;

endmodule

// File: doc/beam_timing_gen.md
Name: beam_timing_gen

Overview:
Parametrised raster timing generator, the next generation of beam_position. Adds configurable h/v timing, configurable sync polarity, a pixel-clock enable, split X/Y coordinates, frame/line start strobes, and a configurable LAT pipeline delay. LAT lets oPos lead DE/HS/VS so a frame-buffer read with fixed latency lines up with the display strobes. It sits between the pixel clock domain and the frame-buffer read port / display PHY.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of oHS (0 = active-low)
VS_POL, 0, active level of oVS
LAT, 0, enabled-cycle delay of oDE/oHS/oVS/strobes relative to oPos/oX/oY (0..15)
POS_W, 19, oPos width; must hold H_ACTIVE*V_ACTIVE
X_W, 10, oX width
Y_W, 10, oY width

Ports:
iClk  in  1  pixel clock
iRst  in  1  asynchronous active-low reset
iEn  in  1  pixel-clock enable; all state advances only when high
oDE  out  1  data enable, delayed by LAT
oHS  out  1  horizontal sync at HS_POL level when asserted, delayed by LAT
oVS  out  1  vertical sync at VS_POL level when asserted, delayed by LAT
oFrameStart  out  1  one-enabled-cycle pulse on pixel (0,0), delayed by LAT
oLineStart  out  1  pulse on pixel x=0 of every active line, delayed by LAT
oPos  out  POS_W  linear pixel address y*H_ACTIVE+x, undelayed
oX  out  X_W  current column (hcnt), undelayed
oY  out  Y_W  current line (vcnt), undelayed

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Horizontal region order is active, FP, sync, BP; vertical order is the same.
- hcnt counts 0..H_TOTAL-1 and wraps to 0 while vcnt increments. vcnt counts 0..V_TOTAL-1 and wraps to 0. Both advance only on an iEn=1 edge.
- Decode from (hcnt,vcnt):
  - de = hcnt<H_ACTIVE && vcnt<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (full lines)
- All outputs are registered, with 1 enabled-cycle latency from the counter state.
- oPos comes from an address counter; no multiplier.
  - Increments after each de pixel.
  - In blanking it holds the address of the next active pixel.
  - Holds H_ACTIVE*V_ACTIVE through vertical blanking.
  - Reloads to 0 on the hcnt/vcnt wrap to (0,0).
- Strobes and de/hs/vs pass through a LAT-stage shift register clocked on iEn. LAT=0 means no extra stage.
- iEn=0: every register holds, including the delay line.
- Reset (async assert, sync release on iClk):
  - Counters, address and delay line cleared.
  - oDE=0, oFrameStart=0, oLineStart=0, oPos=0, oX=0, oY=0.
  - oHS=~HS_POL and oVS=~VS_POL, i.e. the inactive level.
  - Delay-line sync stages reset to the deasserted state, so no spurious sync or DE occurs during LAT fill.
- First enabled edge after release: oX=0, oY=0, oPos=0. With LAT=0 this cycle also has oDE=1 and oFrameStart=1.
- Reset mid-frame: immediate return to the reset values above; the frame restarts at (0,0) with no partial-line strobes.

Optional Feature:
BEAM_LINE_IRQ_EN
- Defined:
  - Adds input iIrqLine [Y_W-1:0] and output oLineIrq.
  - iIrqLine is sampled at the (0,0) wrap.
  - oLineIrq pulses for one enabled cycle at hcnt==H_ACTIVE on line vcnt==sampled iIrqLine, delayed by LAT.
  - No pulse if the sampled value >= V_TOTAL.
  - oLineIrq resets to 0.
- Not defined: neither port exists and no logic is generated.

Test Plan:
- Defaults, iEn=1, reset released at 10 ns, 39.68 ns clock:
  - oFrameStart pulses every 420000 cycles.
  - oDE high for 640 of every 800 cycles on lines 0..479 and low on lines 480..524.
  - oHS low for oX 656..751; oVS low on oY 490..491.
- Address sweep: last active pixel (639,479) gives oPos=307199. oPos=307200 through vertical blanking, then 0 with oX=0, oY=0 after the wrap.
- LAT=3: oDE rises exactly 3 enabled cycles after oPos=0/oX=0. During the first 3 cycles after reset, oDE=0 and oHS/oVS stay inactive.
- iEn toggling 1,0,1,0: all outputs hold on iEn=0 cycles; line length is 1600 clocks.
- Assert iRst low at oX=300, oY=200: outputs take reset values immediately. The first enabled edge after release gives oPos=0, oY=0, oFrameStart=1 (LAT=0).
- With BEAM_LINE_IRQ_EN and iIrqLine=100: oLineIrq pulses once per frame at oY=100, oX=640. With iIrqLine=600, no pulse.
